// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, md_op bit positions,
// divider state encodings and the decode-to-execute bus layout.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 147;
  localparam int ES_TO_MS_BUS_WD = 77;

  localparam int MD_DIV  = 0;
  localparam int MD_DIVU = 1;
  localparam int MD_MFHI = 2;
  localparam int MD_MFLO = 3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Field order is MSB first, matching the packed decode bus.
  typedef struct packed {
    logic [3:0]  md_op;
    logic        exception;
    logic [4:0]  excode;
    logic        src2_is_zero;
    logic [11:0] alu_op;
    logic        load_op;
    logic        src1_is_sa;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        src2_is_8;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } ds_bus_t;

endpackage

// File: rtl/alu.sv
// One-hot controlled 32-bit ALU: add, sub, slt, sltu, and, nor, or, xor,
// sll, srl, sra, lui (bit 0 through bit 11 of alu_op).
module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic        op_sub;
  logic [31:0] adder_b;
  logic [32:0] adder_sum;
  logic        slt_res;
  logic        sltu_res;
  logic [31:0] sra_res;

  // sub, slt and sltu all share the adder as src1 + ~src2 + 1.
  assign op_sub    = alu_op[1] | alu_op[2] | alu_op[3];
  assign adder_b   = op_sub ? ~alu_src2 : alu_src2;
  assign adder_sum = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, op_sub};
  assign slt_res   = (alu_src1[31] & ~alu_src2[31])
                   | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
  assign sltu_res  = ~adder_sum[32];
  assign sra_res   = $signed(alu_src2) >>> alu_src1[4:0];

  always_comb begin
    alu_result = ({32{alu_op[0] | alu_op[1]}} & adder_sum[31:0])
               | ({32{alu_op[2]}}  & {31'd0, slt_res})
               | ({32{alu_op[3]}}  & {31'd0, sltu_res})
               | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
               | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
               | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
               | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
               | ({32{alu_op[8]}}  & (alu_src2 << alu_src1[4:0]))
               | ({32{alu_op[9]}}  & (alu_src2 >> alu_src1[4:0]))
               | ({32{alu_op[10]}} & sra_res)
               | ({32{alu_op[11]}} & {alu_src2[15:0], 16'd0});
  end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for exe_stage (present when DIV_EN is defined):
// one quotient bit per cycle on operand magnitudes, sign fix-up on the way out.
module div_unit
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        flush,
  input  logic        accept,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output div_state_e  state,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] dsr_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic        zero_reg;
  logic [31:0] abs_dividend;
  logic [31:0] abs_divisor;
  logic [32:0] step_tmp;
  logic [32:0] step_diff;
  logic        step_ge;

  assign abs_dividend = (sign & dividend[31]) ? -dividend : dividend;
  assign abs_divisor  = (sign & divisor[31])  ? -divisor  : divisor;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign step_tmp  = {rem_reg, quo_reg[31]};
  assign step_diff = step_tmp - {1'b0, dsr_reg};
  assign step_ge   = ~step_diff[32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= DIV_IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dsr_reg   <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (flush) begin
      state_reg <= DIV_IDLE;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (start) begin
            state_reg <= DIV_BUSY;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= abs_dividend;
            dsr_reg   <= abs_divisor;
            q_neg_reg <= sign & (dividend[31] ^ divisor[31]);
            r_neg_reg <= sign & dividend[31];
            zero_reg  <= (divisor == 32'd0);
          end
        end
        DIV_BUSY: begin
          rem_reg <= step_ge ? step_diff[31:0] : step_tmp[31:0];
          quo_reg <= {quo_reg[30:0], step_ge};
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) state_reg <= DIV_DONE;
        end
        DIV_DONE: begin
          if (accept) state_reg <= DIV_IDLE;
        end
        default: state_reg <= DIV_IDLE;
      endcase
    end
  end

  // A zero divisor leaves the core with an all-ones quotient and |dividend|
  // as remainder; only the quotient must bypass the sign fix-up.
  assign state     = state_reg;
  assign quotient  = zero_reg  ? 32'hFFFF_FFFF : (q_neg_reg ? -quo_reg : quo_reg);
  assign remainder = r_neg_reg ? -rem_reg : rem_reg;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: operand select, ALU, data-SRAM request and forwarding
// info for decode. DIV_EN adds the iterative divider with HI/LO registers.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       es_load_op,
  output logic [31:0]                es_to_ds_result,
  output logic [4:0]                 ES_dest,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_wen,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  ds_bus_t     es_bus_reg;
  logic        es_valid_reg;
  logic        es_ready_go;
  logic        store_en;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_result;
  logic [31:0] hi_val;
  logic [31:0] lo_val;
  logic [31:0] es_result;

  assign es_allowin     = ~es_valid_reg | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_reg & es_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_reg <= 1'b0;
    end else if (flush) begin
      es_valid_reg <= 1'b0;
    end else if (es_allowin) begin
      es_valid_reg <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_bus_reg <= '0;
    end else if (ds_to_es_valid & es_allowin) begin
      es_bus_reg <= ds_to_es_bus;
    end
  end

  assign src1 = es_bus_reg.src1_is_sa ? {27'd0, es_bus_reg.imm[10:6]} :
                es_bus_reg.src1_is_pc ? es_bus_reg.pc : es_bus_reg.rs_value;
  assign src2 = (es_bus_reg.src2_is_imm & es_bus_reg.src2_is_zero) ? {16'd0, es_bus_reg.imm} :
                es_bus_reg.src2_is_imm ? {{16{es_bus_reg.imm[15]}}, es_bus_reg.imm} :
                es_bus_reg.src2_is_8   ? 32'd8 : es_bus_reg.rt_value;

  alu u_alu (
    .alu_op     (es_bus_reg.alu_op),
    .alu_src1   (src1),
    .alu_src2   (src2),
    .alu_result (alu_result)
  );

  assign es_result = es_bus_reg.md_op[MD_MFHI] ? hi_val :
                     es_bus_reg.md_op[MD_MFLO] ? lo_val : alu_result;

`ifdef DIV_EN
  div_state_e  div_state;
  logic        div_op;
  logic        div_start;
  logic        div_accept;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  // An excepting divide is not a divide: it must flow through in one cycle.
  assign div_op      = (es_bus_reg.md_op[MD_DIV] | es_bus_reg.md_op[MD_DIVU]) & ~es_bus_reg.exception;
  assign div_start   = es_valid_reg & div_op & ~flush;
  assign div_accept  = es_to_ms_valid & ms_allowin;
  assign es_ready_go = ~div_op | (div_state == DIV_DONE);

  div_unit u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .flush     (flush),
    .accept    (div_accept),
    .sign      (es_bus_reg.md_op[MD_DIV]),
    .dividend  (es_bus_reg.rs_value),
    .divisor   (es_bus_reg.rt_value),
    .state     (div_state),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (div_accept & div_op & (div_state == DIV_DONE) & ~flush) begin
      hi_reg <= remainder;
      lo_reg <= quotient;
    end
  end

  assign hi_val = hi_reg;
  assign lo_val = lo_reg;
`else
  logic unused_md_op;

  assign unused_md_op = ^es_bus_reg.md_op[MD_DIVU:MD_DIV];
  assign es_ready_go  = 1'b1;
  assign hi_val       = 32'd0;
  assign lo_val       = 32'd0;
`endif

  assign es_to_ms_bus = {es_bus_reg.exception, es_bus_reg.excode, es_bus_reg.load_op,
                         es_bus_reg.gr_we, es_bus_reg.dest, es_result, es_bus_reg.pc};

  assign es_load_op      = es_valid_reg & es_bus_reg.load_op;
  assign es_to_ds_result = es_result;
  assign ES_dest         = (es_valid_reg & es_bus_reg.gr_we) ? es_bus_reg.dest : 5'd0;

  assign store_en        = es_valid_reg & es_bus_reg.mem_we & ~es_bus_reg.exception & ~flush;
  assign data_sram_en    = es_valid_reg & (es_bus_reg.load_op | es_bus_reg.mem_we);
  assign data_sram_addr  = es_result;
  assign data_sram_wdata = es_bus_reg.rt_value;

  for (genvar gi = 0; gi < 4; gi++) begin : g_wen
    assign data_sram_wen[gi] = store_en;
  end

endmodule
